// File: rtl/stats_frame_tx_pkg.sv
// Shared definitions for the run-statistics frame transmitter and its host-side decoder model.
package stats_frame_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StCheck,
    StSent
  } tx_state_e;

  localparam logic [7:0]  HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned NUM_STAT_WORDS      = 5;

endpackage

// File: rtl/stats_word_shifter.sv
// Holds the counter snapshot and presents it one byte at a time, MSB first.
module stats_word_shifter
  import stats_frame_tx_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load,
  input  logic [NUM_STAT_WORDS*WORD_W-1:0] load_data,
  input  logic                             shift,
  output logic [7:0]                       byte_out
);

  localparam int unsigned SnapW = NUM_STAT_WORDS * WORD_W;

  logic [SnapW-1:0] snap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q <= '0;
    end else if (load) begin
      snap_q <= load_data;
    end else if (shift) begin
      snap_q <= {snap_q[SnapW-9:0], 8'h00};
    end
  end

  assign byte_out = snap_q[SnapW-1 -: 8];

endmodule

// File: rtl/stats_frame_tx.sv
// Snapshots the five run counters on done and streams them as a checksummed byte frame.
module stats_frame_tx
  import stats_frame_tx_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEFAULT,
  parameter int unsigned WORD_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              done,
  input  logic [WORD_W-1:0] num_inst,
  input  logic [WORD_W-1:0] num_noops_min,
  input  logic [WORD_W-1:0] num_noops_max,
  input  logic [WORD_W-1:0] num_mispredicts,
  input  logic [WORD_W-1:0] result,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [7:0]        frames_sent
);

  localparam int unsigned PayloadBytes = NUM_STAT_WORDS * WORD_W / 8;
  localparam int unsigned CntW         = $clog2(PayloadBytes + 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      csum_q;
  logic [7:0]      frames_q;
  logic [7:0]      payload_byte;
  logic            accept;
  logic            load;
  logic            shift;
  logic            last_payload;

  assign accept       = tx_valid && tx_ready;
  assign load         = (state_q == StIdle) && done;
  assign shift        = (state_q == StPayload) && accept;
  assign last_payload = (cnt_q == CntW'(PayloadBytes - 1));

  stats_word_shifter #(
    .WORD_W(WORD_W)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_data({num_inst, num_noops_min, num_noops_max, num_mispredicts, result}),
    .shift    (shift),
    .byte_out (payload_byte)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (done) state_d = StHeader;
      StHeader:  if (accept) state_d = StPayload;
      StPayload: if (accept && last_payload) state_d = StCheck;
      StCheck:   if (accept) state_d = StSent;
      // Hold here until done drops so one level-high done yields one frame.
      StSent:    if (!done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    busy     = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      StHeader: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = HEADER_BYTE;
      end
      StPayload: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = payload_byte;
      end
      StCheck: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = csum_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      csum_q   <= 8'h00;
      frames_q <= 8'h00;
    end else begin
      if (load) begin
        cnt_q  <= '0;
        csum_q <= 8'h00;
      end
      if (shift) begin
        cnt_q  <= cnt_q + 1'b1;
        csum_q <= csum_q ^ payload_byte;
      end
      if ((state_q == StCheck) && accept) begin
        frames_q <= frames_q + 8'd1;
      end
    end
  end

  assign frames_sent = frames_q;

endmodule

// File: tb/tb_stats_frame_tx.sv
// Randomised bench for stats_frame_tx against a queue-based frame model, plus literal frames.
module tb_stats_frame_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        done;
  logic [31:0] num_inst, num_noops_min, num_noops_max, num_mispredicts, result;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  frames_sent;

  always #5 clock = ~clock;

  stats_frame_tx dut (
    .clock          (clock),
    .reset          (reset),
    .done           (done),
    .num_inst       (num_inst),
    .num_noops_min  (num_noops_min),
    .num_noops_max  (num_noops_max),
    .num_mispredicts(num_mispredicts),
    .result         (result),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .frames_sent    (frames_sent)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  // Model: bytes still owed to the sink, whether a done re-arm is pending, completed frames.
  logic [7:0] exp_q[$];
  bit         wait_low = 1'b0;
  int         m_frames = 0;
  logic [7:0] rec[$];
  int         valid_cycles;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  logic [7:0] lit12345[22] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                               8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04,
                               8'h00, 8'h00, 8'h00, 8'h05, 8'h01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic build_frame();
    logic [31:0] w[5];
    logic [7:0]  cs;
    logic [7:0]  b;
    cs = 8'h00;
    w  = '{num_inst, num_noops_min, num_noops_max, num_mispredicts, result};
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 5; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b = w[i][8*j +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  // One clock: compare at negedge, then advance the model on the posedge.
  task automatic tick();
    logic       ev;
    logic [7:0] ed;
    @(negedge clock);
    ev = (exp_q.size() != 0);
    ed = ev ? exp_q[0] : 8'h00;
    chk("tx_valid", tx_valid, ev);
    chk("busy", busy, ev);
    chk("tx_data", tx_data, ed);
    chk("frames_sent", frames_sent, m_frames % 256);
    if (prev_stall && tx_valid) chk("stall_hold", tx_data, prev_data);
    prev_stall = tx_valid && !tx_ready && !reset;
    prev_data  = tx_data;
    if (!reset) begin
      if (tx_valid) valid_cycles++;
      if (tx_valid && tx_ready) rec.push_back(tx_data);
    end
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      wait_low = 1'b0;
      m_frames = 0;
    end else if (exp_q.size() != 0) begin
      if (tx_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_frames++;
          wait_low = 1'b1;
        end
      end
    end else if (wait_low) begin
      if (!done) wait_low = 1'b0;
    end else if (done) begin
      build_frame();
    end
    #1;
  endtask

  task automatic randomize_inputs();
    num_inst        = $urandom;
    num_noops_min   = $urandom;
    num_noops_max   = $urandom;
    num_mispredicts = $urandom;
    result          = $urandom;
  endtask

  // mode 0: ready always 1; 1: ready toggles 1/0; 2: random ready and random done after start.
  task automatic run_frame(input int mode, input int budget, input bit scramble);
    logic [7:0] start;
    bit         got;
    start = frames_sent;
    got   = 1'b0;
    rec.delete();
    valid_cycles = 0;
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (c % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (c > 0 && mode == 2) done = 1'($urandom_range(0, 1));
      if (c > 0 && scramble) randomize_inputs();
      tick();
      if (frames_sent != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_lit(input string name, input logic [7:0] e[22]);
    chk({name, "_len"}, rec.size(), 22);
    for (int i = 0; i < 22 && i < rec.size(); i++) chk({name, "_byte"}, rec[i], e[i]);
  endtask

  task automatic set_inputs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] d, input logic [31:0] e);
    num_inst        = a;
    num_noops_min   = b;
    num_noops_max   = c;
    num_mispredicts = d;
    result          = e;
  endtask

  initial begin
    int   guard;
    logic [7:0] base;
    reset    = 1'b1;
    done     = 1'b0;
    tx_ready = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;

    // Idle with done low: nothing leaves.
    repeat (20) begin
      tick();
      chk("idle_valid", tx_valid, 0);
    end
    chk("idle_frames", frames_sent, 0);

    // Basic frame, ready always high.
    set_inputs(1, 2, 3, 4, 5);
    done = 1'b1;
    run_frame(0, 60, 1'b0);
    cmp_lit("f1", lit12345);
    chk("f1_valid_cycles", valid_cycles, 22);
    chk("f1_frames", frames_sent, 1);
    done = 1'b0;
    repeat (2) tick();

    // Same frame with ready toggling and inputs scrambled after the snapshot.
    done = 1'b1;
    run_frame(1, 100, 1'b1);
    cmp_lit("f2", lit12345);
    chk("f2_frames", frames_sent, 2);
    done = 1'b0;
    repeat (2) tick();

    // Checksum of a lone DEADBEEF word.
    set_inputs(0, 0, 0, 0, 32'hDEADBEEF);
    done = 1'b1;
    run_frame(0, 60, 1'b0);
    chk("beef_len", rec.size(), 22);
    if (rec.size() == 22) begin
      chk("beef_hdr", rec[0], 8'hA5);
      chk("beef_csum", rec[21], 8'h22);
    end
    done = 1'b0;
    repeat (2) tick();

    // Done held high: exactly one frame; a one-cycle drop re-arms.
    base = frames_sent;
    randomize_inputs();
    done = 1'b1;
    run_frame(0, 60, 1'b0);
    repeat (100) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("hold_one_frame", frames_sent, base + 8'd1);
    done = 1'b0;
    tick();
    done = 1'b1;
    run_frame(0, 60, 1'b0);
    chk("rearm_frames", frames_sent, base + 8'd2);
    chk("rearm_len", rec.size(), 22);
    done = 1'b0;
    repeat (2) tick();

    // Reset while payload byte 7 is on offer.
    randomize_inputs();
    done     = 1'b1;
    tx_ready = 1'b1;
    rec.delete();
    guard = 0;
    while (rec.size() < 8 && guard < 60) begin
      tick();
      guard++;
    end
    chk("pre_reset_count", rec.size(), 8);
    reset = 1'b1;
    randomize_inputs();
    tick();
    reset = 1'b0;
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    run_frame(0, 60, 1'b0);
    chk("post_rst_len", rec.size(), 22);
    if (rec.size() != 0) chk("post_rst_hdr", rec[0], 8'hA5);
    chk("post_rst_frames", frames_sent, 1);
    done = 1'b0;
    repeat (2) tick();

    // Random frames with random stalls, done wobbling mid-frame.
    for (int k = 0; k < 10; k++) begin
      randomize_inputs();
      done = 1'b1;
      run_frame(2, 400, 1'b1);
      chk("rand_len", rec.size(), 22);
      done = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end
    chk("rand_frames", frames_sent, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
